floo_no_rob_tracker: RTL and testbench
======================================

Name: floo_no_rob_tracker

Overview:
Response-side ordering guard for network-interface channels configured with the `NoRoB` reorder-buffer type.
- Tracks outstanding AXI transactions per txnID: the request path increments, the returning response path decrements.
- Stalls a new request whose txnID is still outstanding towards a different destination, so responses per ID return in order without a reorder buffer.
- Sits between the AXI Ax request port and the flit packer of the chimney, and observes the B or R response returning from the network.

Parameters:
IdWidth, 4, width of the AXI txnID; NumIds = 2**IdWidth tracked IDs
DestWidth, 8, width of the destination identifier (node ID or packed XY coordinate)
MaxTxnsPerId, 32, maximum outstanding transactions per txnID; must be >= 1
CntWidth, $clog2(MaxTxnsPerId+1), width of each per-ID counter (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
ax_valid_i  in  1  request valid from AXI manager side
ax_ready_o  out  1  request ready to AXI manager side
ax_id_i  in  IdWidth  txnID of the offered request
ax_dest_i  in  DestWidth  destination of the offered request
ax_valid_o  out  1  gated request valid towards the packer
ax_ready_i  in  1  request ready from the packer
rsp_valid_i  in  1  response valid (monitor only)
rsp_ready_i  in  1  response ready (monitor only)
rsp_id_i  in  IdWidth  txnID of the response
rsp_last_i  in  1  last beat of the response; tie to 1 for B
idle_o  out  1  high when every per-ID counter is zero
err_o  out  1  one-cycle pulse: response retired for an ID with zero outstanding transactions

Behaviour:
- Per-ID state:
  - cnt[id] is CntWidth bits; dest[id] is DestWidth bits.
  - Reset (asynchronous, rst_ni low): all cnt = 0, all dest = 0, err_o = 0.
  - Reset mid-operation discards all tracking state, with no replay.
- Stall (combinational):
  - stall = ax_valid_i && (cnt[ax_id_i] == MaxTxnsPerId || (cnt[ax_id_i] != 0 && dest[ax_id_i] != ax_dest_i)).
- Gating:
  - ax_valid_o = ax_valid_i && !stall.
  - ax_ready_o = ax_ready_i && !stall.
  - There is no combinational path from any rsp_* input to ax_valid_o or ax_ready_o.
  - A response retiring in the same cycle does not unblock a stalled request; the request proceeds the following cycle.
- Once asserted and not stalled, ax_valid_o must be held while ax_ready_i is low, provided the upstream side keeps ax_valid_i, ax_id_i and ax_dest_i stable (AXI rule).
- Increment: on ax_valid_o && ax_ready_i, cnt[ax_id_i] += 1 and dest[ax_id_i] <= ax_dest_i.
- Retire: rsp_valid_i && rsp_ready_i && rsp_last_i.
  - If cnt[rsp_id_i] != 0: cnt[rsp_id_i] -= 1.
  - If cnt[rsp_id_i] == 0: counter stays 0 and err_o pulses high on the next cycle; the simulation assertion fires.
  - Non-last beats never change state.
- Simultaneous increment and retire:
  - Same ID: cnt unchanged; dest written with ax_dest_i (equal to the stored value, since the request was not stalled).
  - Different IDs: both updates apply independently.
- Per-ID state machine, derived from the counter:
  - IDLE (cnt == 0, any dest accepted).
  - ACTIVE (1 <= cnt < MaxTxnsPerId, only dest[id] accepted).
  - FULL (cnt == MaxTxnsPerId, all stalled).
  - Transitions: IDLE->ACTIVE on increment; ACTIVE->FULL on increment reaching the max; FULL->ACTIVE on retire; ACTIVE->IDLE on retire reaching 0.
  - When MaxTxnsPerId = 1: IDLE->FULL directly.
- Counters never wrap: increment at the max is impossible (stalled) and decrement at 0 is blocked.
- idle_o is registered-state derived: the OR-reduction of all cnt, inverted, with no input dependency. It is 1 after reset.
- Latency: zero cycles on the request path (pure gating); one cycle for a state update to affect stall.

Test Plan:
- Reset, then ID 3 to dest 0x05, ax_ready_i = 1 -> handshake same cycle; cnt[3] = 1, idle_o = 0 next cycle.
- ID 3 outstanding to 0x05, new ID 3 request to 0x07 -> ax_valid_o = 0, ax_ready_o = 0. Retire ID 3 with rsp_last_i = 1 -> request accepted one cycle after the retire, dest[3] = 0x07.
- Issue 32 requests, ID 1, dest 0x02 -> the 33rd is stalled. Retire one -> the 33rd is accepted next cycle; cnt[1] stays 32.
- Same-cycle increment and retire on ID 2 (cnt = 4) -> cnt[2] = 4. Same-cycle on IDs 2 and 6 -> cnt[2] = 5, cnt[6] decremented.
- R burst of 4 beats on ID 0 with only the 4th beat having last -> cnt[0] decrements once. Response on ID 9 with cnt = 0 -> err_o = 1 for exactly one cycle, cnt[9] = 0.
- Assert rst_ni low with 3 IDs outstanding -> all counters 0 and idle_o = 1 immediately (asynchronous). A prior-destination conflict no longer stalls after reset release.

Source files
------------

// File: rtl/floo_no_rob_tracker.sv
// Per-txnID ordering guard for NoRoB channels: counts outstanding requests per ID
// and stalls a request whose ID is still in flight towards a different destination.
module floo_no_rob_tracker #(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned DestWidth    = 8,
  parameter int unsigned MaxTxnsPerId = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [DestWidth-1:0] ax_dest_i,
  output logic                 ax_valid_o,
  input  logic                 ax_ready_i,
  input  logic                 rsp_valid_i,
  input  logic                 rsp_ready_i,
  input  logic [IdWidth-1:0]   rsp_id_i,
  input  logic                 rsp_last_i,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam int unsigned NumIds   = 1 << IdWidth;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);

  // Per-ID state derived from the counter; exposed for checkers.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StFull   = 2'd2;

  logic [CntWidth-1:0]  cnt_q  [NumIds];
  logic [DestWidth-1:0] dest_q [NumIds];
  logic [1:0]           state  [NumIds];
  logic                 err_q;

  logic stall;
  logic inc;
  logic retire;
  logic retire_empty;

  // Handshake: a request transfers on ax_valid_o && ax_ready_i; stall only depends
  // on registered state and the current request, never on the response inputs.
  always_comb begin
    stall = ax_valid_i &&
            ((cnt_q[ax_id_i] == CntMax) ||
             ((cnt_q[ax_id_i] != '0) && (dest_q[ax_id_i] != ax_dest_i)));
  end

  assign ax_valid_o   = ax_valid_i && !stall;
  assign ax_ready_o   = ax_ready_i && !stall;
  assign inc          = ax_valid_o && ax_ready_i;
  assign retire       = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign retire_empty = retire && (cnt_q[rsp_id_i] == '0);

  always_comb begin
    idle_o = 1'b1;
    for (int i = 0; i < NumIds; i++) begin
      if (cnt_q[i] != '0) idle_o = 1'b0;
      if (cnt_q[i] == '0)         state[i] = StIdle;
      else if (cnt_q[i] == CntMax) state[i] = StFull;
      else                         state[i] = StActive;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i]  <= '0;
        dest_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        logic inc_i;
        logic dec_i;
        inc_i = inc && (ax_id_i == IdWidth'(i));
        // A retire on an empty counter is blocked so counters never wrap.
        dec_i = retire && (rsp_id_i == IdWidth'(i)) && (cnt_q[i] != '0);
        if (inc_i && !dec_i)      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_i && !inc_i) cnt_q[i] <= cnt_q[i] - 1'b1;
        if (inc_i) dest_q[i] <= ax_dest_i;
      end
      err_q <= retire_empty;
    end
  end

  assign err_o = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!retire_empty)
        else $warning("retire on txnID %0d with no outstanding transactions", rsp_id_i);
    end
  end
`endif

endmodule

// File: tb/tb_floo_no_rob_tracker.sv
// Directed bench for floo_no_rob_tracker: hand-computed expectations checked by
// immediate assertions, counter state observed through the DUT hierarchy.
module tb_floo_no_rob_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ax_valid_i;
  logic       ax_ready_o;
  logic [3:0] ax_id_i;
  logic [7:0] ax_dest_i;
  logic       ax_valid_o;
  logic       ax_ready_i;
  logic       rsp_valid_i;
  logic       rsp_ready_i;
  logic [3:0] rsp_id_i;
  logic       rsp_last_i;
  logic       idle_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  floo_no_rob_tracker #(.IdWidth(4), .DestWidth(8), .MaxTxnsPerId(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ax_valid_i(ax_valid_i), .ax_ready_o(ax_ready_o),
    .ax_id_i(ax_id_i), .ax_dest_i(ax_dest_i),
    .ax_valid_o(ax_valid_o), .ax_ready_i(ax_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i),
    .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic req(input logic v, input logic [3:0] id, input logic [7:0] dest);
    ax_valid_i = v;
    ax_id_i    = id;
    ax_dest_i  = dest;
  endtask

  task automatic rsp(input logic v, input logic [3:0] id, input logic last);
    rsp_valid_i = v;
    rsp_id_i    = id;
    rsp_last_i  = last;
  endtask

  initial begin
    rst_ni      = 1'b0;
    ax_ready_i  = 1'b1;
    rsp_ready_i = 1'b1;
    req(1'b0, 4'd0, 8'd0);
    rsp(1'b0, 4'd0, 1'b0);
    #12;
    chk("reset_idle", 32'(idle_o), 32'd1);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_valid_o", 32'(ax_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // First request ID 3 -> 0x05 handshakes in the same cycle.
    req(1'b1, 4'd3, 8'h05);
    #1;
    chk("first_valid_o", 32'(ax_valid_o), 32'd1);
    chk("first_ready_o", 32'(ax_ready_o), 32'd1);
    step();
    req(1'b0, 4'd0, 8'd0);
    #1;
    chk("first_cnt3", 32'(dut.cnt_q[3]), 32'd1);
    chk("first_idle", 32'(idle_o), 32'd0);

    // Packer not ready: valid passes through, nothing counted.
    ax_ready_i = 1'b0;
    req(1'b1, 4'd4, 8'h11);
    #1;
    chk("noready_valid_o", 32'(ax_valid_o), 32'd1);
    chk("noready_ready_o", 32'(ax_ready_o), 32'd0);
    step();
    chk("noready_valid_hold", 32'(ax_valid_o), 32'd1);
    chk("noready_cnt4", 32'(dut.cnt_q[4]), 32'd0);
    ax_ready_i = 1'b1;
    req(1'b0, 4'd0, 8'd0);

    // Destination conflict on ID 3; same-cycle retire must not unblock.
    req(1'b1, 4'd3, 8'h07);
    #1;
    chk("conflict_valid_o", 32'(ax_valid_o), 32'd0);
    chk("conflict_ready_o", 32'(ax_ready_o), 32'd0);
    rsp(1'b1, 4'd3, 1'b1);
    #1;
    chk("conflict_retire_same_cycle", 32'(ax_valid_o), 32'd0);
    step();
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("conflict_cnt3_zero", 32'(dut.cnt_q[3]), 32'd0);
    chk("conflict_after_retire", 32'(ax_valid_o), 32'd1);
    step();
    req(1'b0, 4'd0, 8'd0);
    #1;
    chk("conflict_cnt3", 32'(dut.cnt_q[3]), 32'd1);
    chk("conflict_dest3", 32'(dut.dest_q[3]), 32'h07);

    // Fill ID 1 to the maximum of 32.
    req(1'b1, 4'd1, 8'h02);
    for (int i = 0; i < 32; i++) step();
    #1;
    chk("full_cnt1", 32'(dut.cnt_q[1]), 32'd32);
    chk("full_stall_valid", 32'(ax_valid_o), 32'd0);
    chk("full_stall_ready", 32'(ax_ready_o), 32'd0);
    rsp(1'b1, 4'd1, 1'b1);
    #1;
    chk("full_retire_same_cycle", 32'(ax_valid_o), 32'd0);
    step();
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("full_after_retire_cnt1", 32'(dut.cnt_q[1]), 32'd31);
    chk("full_after_retire_valid", 32'(ax_valid_o), 32'd1);
    step();
    req(1'b0, 4'd0, 8'd0);
    #1;
    chk("full_refill_cnt1", 32'(dut.cnt_q[1]), 32'd32);
    rsp(1'b1, 4'd1, 1'b1);
    for (int i = 0; i < 32; i++) step();
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("drain_cnt1", 32'(dut.cnt_q[1]), 32'd0);

    // ID 2 to 4 outstanding, ID 6 to 2 outstanding.
    req(1'b1, 4'd2, 8'h04);
    for (int i = 0; i < 4; i++) step();
    req(1'b1, 4'd6, 8'h06);
    for (int i = 0; i < 2; i++) step();
    req(1'b0, 4'd0, 8'd0);
    #1;
    chk("setup_cnt2", 32'(dut.cnt_q[2]), 32'd4);
    chk("setup_cnt6", 32'(dut.cnt_q[6]), 32'd2);
    req(1'b1, 4'd2, 8'h04);
    rsp(1'b1, 4'd2, 1'b1);
    step();
    #1;
    chk("same_id_cnt2", 32'(dut.cnt_q[2]), 32'd4);
    rsp(1'b1, 4'd6, 1'b1);
    step();
    req(1'b0, 4'd0, 8'd0);
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("diff_id_cnt2", 32'(dut.cnt_q[2]), 32'd5);
    chk("diff_id_cnt6", 32'(dut.cnt_q[6]), 32'd1);

    // R burst on ID 0: only the last beat retires.
    req(1'b1, 4'd0, 8'h01);
    step();
    req(1'b0, 4'd0, 8'd0);
    rsp(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("burst_nonlast_cnt0", 32'(dut.cnt_q[0]), 32'd1);
    rsp(1'b1, 4'd0, 1'b1);
    step();
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("burst_last_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    chk("burst_no_err", 32'(err_o), 32'd0);

    // Spurious retire on empty ID 9.
    rsp(1'b1, 4'd9, 1'b1);
    step();
    rsp(1'b0, 4'd0, 1'b0);
    #1;
    chk("spurious_err_pulse", 32'(err_o), 32'd1);
    chk("spurious_cnt9", 32'(dut.cnt_q[9]), 32'd0);
    step();
    chk("spurious_err_clear", 32'(err_o), 32'd0);

    // Asynchronous reset with IDs 2, 3 and 6 outstanding.
    chk("prereset_idle", 32'(idle_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("async_idle", 32'(idle_o), 32'd1);
    chk("async_cnt2", 32'(dut.cnt_q[2]), 32'd0);
    chk("async_cnt3", 32'(dut.cnt_q[3]), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req(1'b1, 4'd3, 8'h09);
    #1;
    chk("postreset_no_stall", 32'(ax_valid_o), 32'd1);
    step();
    req(1'b0, 4'd0, 8'd0);
    #1;
    chk("postreset_cnt3", 32'(dut.cnt_q[3]), 32'd1);
    chk("postreset_dest3", 32'(dut.dest_q[3]), 32'h09);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
